// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding and default tuning constants for the PLL acquisition sequencer.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SWEEP    = 3'd1,
    ST_TRACK    = 3'd2,
    ST_LOCKED   = 3'd3,
    ST_HOLDOVER = 3'd4
  } pll_state_e;

  localparam int DEF_FW         = 10;
  localparam int DEF_DWELL_LOG2 = 14;
  localparam int DEF_SWEEP_STEP = 4;
  localparam int DEF_WIN_LOG2   = 16;
  localparam int DEF_LOCK_MAX   = 32;
  localparam int DEF_LOCK_WINS  = 4;
  localparam int DEF_NOSIG      = 2000;

endpackage

// File: rtl/pll_win_meter.sv
// Measurement window for the acquisition sequencer: a restartable 2^N counter whose length
// is picked at runtime by a mask, plus saturating slew-active and feedback-edge counts.
module pll_win_meter
  import pll_ctrl_pkg::*;
#(
  parameter int CW = 16,
  parameter int SW = CW + 1
) (
  input  logic          clk_50,
  input  logic          rst_n,
  input  logic          restart,
  input  logic [CW-1:0] mask,
  input  logic          slew_act,
  input  logic          fb_edge,
  output logic          win_end,
  output logic [SW-1:0] slew_cnt,
  output logic [SW-1:0] edge_cnt
);

  logic [CW-1:0] win_cnt;
  logic [SW-1:0] slew_acc;
  logic [SW-1:0] edge_acc;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v, input logic inc);
    return (&v) ? v : v + {{(SW-1){1'b0}}, inc};
  endfunction

  // Counts reported at win_end already include the current cycle.
  assign win_end  = (win_cnt & mask) == mask;
  assign slew_cnt = sat_inc(slew_acc, slew_act);
  assign edge_cnt = sat_inc(edge_acc, fb_edge);

  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      win_cnt <= '0;
    end else if (restart || win_end) begin
      win_cnt <= '0;
    end else begin
      win_cnt <= win_cnt + CW'(1);
    end
  end

  // Accumulators are cleared by restart, which the sequencer holds while idle.
  always_ff @(posedge clk_50) begin
    if (restart || win_end) begin
      slew_acc <= '0;
      edge_acc <= '0;
    end else begin
      slew_acc <= slew_cnt;
      edge_acc <= edge_cnt;
    end
  end

endmodule

// File: rtl/pll_acq_ctrl.sv
// NCO acquisition/lock sequencer: sweeps the frequency word, hands over to tracking,
// declares lock from slew activity. Define PLL_ACQ_HOLDOVER_EN to build the holdover state.
module pll_acq_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int FW         = DEF_FW,
  parameter int DWELL_LOG2 = DEF_DWELL_LOG2,
  parameter int SWEEP_STEP = DEF_SWEEP_STEP,
  parameter int WIN_LOG2   = DEF_WIN_LOG2,
  parameter int LOCK_MAX   = DEF_LOCK_MAX,
  parameter int LOCK_WINS  = DEF_LOCK_WINS,
  parameter int NOSIG      = DEF_NOSIG
) (
  input  logic          clk_50,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          fb_edge,
  input  logic          slew_fast,
  input  logic          slew_slow,
  input  logic [FW-1:0] freq_min,
  input  logic [FW-1:0] freq_max,
  input  logic [FW-1:0] freq_cur,
  output logic          freq_load,
  output logic [FW-1:0] freq_set,
  output logic          track_en,
  output logic          locked,
  output logic          holdover,
  output logic [2:0]    state
);

  localparam int CW = (WIN_LOG2 > DWELL_LOG2) ? WIN_LOG2 : DWELL_LOG2;
  localparam int SW = CW + 1;
  localparam int NW = $clog2(NOSIG + 1);
  localparam int GW = $clog2(LOCK_WINS + 1);

  localparam logic [CW-1:0] DWELL_MASK = CW'((64'd1 << DWELL_LOG2) - 64'd1);
  localparam logic [CW-1:0] WIN_MASK   = CW'((64'd1 << WIN_LOG2) - 64'd1);
  localparam logic [SW-1:0] DWELL_HALF = SW'(64'd1 << (DWELL_LOG2 - 1));
  localparam logic [SW-1:0] QUIET_MAX  = SW'(LOCK_MAX);
  localparam logic [SW-1:0] MIN_EDGES  = SW'(2);
  localparam logic [FW:0]   STEP_W     = (FW+1)'(SWEEP_STEP);
  localparam logic [NW-1:0] NOSIG_W    = NW'(NOSIG);
  localparam logic [GW-1:0] WINS_W     = GW'(LOCK_WINS);

  pll_state_e    st, st_nxt;
  logic [FW-1:0] freq_set_nxt;
  logic          load_nxt;
  logic [GW-1:0] good, good_nxt, good_inc;
  logic [NW-1:0] nosig_cnt;
  logic          lost, railed, quiet;
  logic [FW:0]   step_sum;

  logic          restart;
  logic [CW-1:0] win_mask;
  logic          win_end;
  logic [SW-1:0] slew_cnt, edge_cnt;

  assign restart  = (st_nxt != st) || (st == ST_IDLE);
  assign win_mask = (st == ST_SWEEP) ? DWELL_MASK : WIN_MASK;

  pll_win_meter #(
    .CW(CW),
    .SW(SW)
  ) u_meter (
    .clk_50  (clk_50),
    .rst_n   (rst_n),
    .restart (restart),
    .mask    (win_mask),
    .slew_act(slew_fast | slew_slow),
    .fb_edge (fb_edge),
    .win_end (win_end),
    .slew_cnt(slew_cnt),
    .edge_cnt(edge_cnt)
  );

  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      nosig_cnt <= '0;
    end else if (fb_edge) begin
      nosig_cnt <= '0;
    end else if (nosig_cnt != NOSIG_W) begin
      nosig_cnt <= nosig_cnt + NW'(1);
    end
  end

  assign lost     = (nosig_cnt == NOSIG_W);
  assign railed   = (freq_cur == freq_min) || (freq_cur == freq_max);
  assign quiet    = (slew_cnt <= QUIET_MAX);
  assign step_sum = {1'b0, freq_set} + STEP_W;
  assign good_inc = good + GW'(1);

  // Loss of signal is held off for one cycle after a load so loads never abut.
  always_comb begin
    st_nxt       = st;
    freq_set_nxt = freq_set;
    load_nxt     = 1'b0;
    good_nxt     = good;
    if (!enable) begin
      st_nxt = ST_IDLE;
    end else if (lost && !freq_load && (st == ST_TRACK || st == ST_LOCKED)) begin
`ifdef PLL_ACQ_HOLDOVER_EN
      st_nxt       = ST_HOLDOVER;
      freq_set_nxt = freq_cur;
      load_nxt     = 1'b1;
`else
      st_nxt       = ST_SWEEP;
      freq_set_nxt = freq_min;
      load_nxt     = 1'b1;
`endif
    end else begin
      case (st)
        ST_IDLE: begin
          st_nxt       = ST_SWEEP;
          freq_set_nxt = freq_min;
          load_nxt     = 1'b1;
        end
        ST_SWEEP: begin
          if (win_end) begin
            load_nxt = 1'b1;
            if (edge_cnt >= MIN_EDGES && slew_cnt < DWELL_HALF) begin
              st_nxt = ST_TRACK;
            end else if (step_sum > {1'b0, freq_max}) begin
              freq_set_nxt = freq_min;
            end else begin
              freq_set_nxt = step_sum[FW-1:0];
            end
          end
        end
        ST_TRACK: begin
          if (win_end) begin
            if (railed) begin
              st_nxt       = ST_SWEEP;
              freq_set_nxt = freq_min;
              load_nxt     = 1'b1;
            end else if (quiet) begin
              if (good_inc == WINS_W) begin
                st_nxt = ST_LOCKED;
              end else begin
                good_nxt = good_inc;
              end
            end else begin
              good_nxt = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (win_end && !quiet) begin
            st_nxt = ST_TRACK;
          end
        end
`ifdef PLL_ACQ_HOLDOVER_EN
        ST_HOLDOVER: begin
          if (fb_edge) begin
            st_nxt = ST_TRACK;
          end
        end
`endif
        default: st_nxt = ST_IDLE;
      endcase
    end
  end

  // Registered state and outputs; flags are decoded from the next state.
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      freq_set  <= '0;
      freq_load <= 1'b0;
      track_en  <= 1'b0;
      locked    <= 1'b0;
      good      <= '0;
    end else begin
      st        <= st_nxt;
      freq_set  <= freq_set_nxt;
      freq_load <= load_nxt;
      track_en  <= (st_nxt == ST_TRACK) || (st_nxt == ST_LOCKED);
      locked    <= (st_nxt == ST_LOCKED);
      good      <= (st == ST_TRACK && st_nxt == ST_TRACK) ? good_nxt : '0;
    end
  end

`ifdef PLL_ACQ_HOLDOVER_EN
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      holdover <= 1'b0;
    end else begin
      holdover <= (st_nxt == ST_HOLDOVER);
    end
  end
`else
  assign holdover = 1'b0;
`endif

  assign state = st;

endmodule

// File: tb/tb_pll_acq_ctrl.sv
// Directed bench for pll_acq_ctrl with shortened windows (dwell 32, window 64, NOSIG 50).
module tb_pll_acq_ctrl;

  localparam int FW = 10;

  logic          clk_50 = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          fb_edge = 1'b0;
  logic          slew_fast = 1'b0;
  logic          slew_slow = 1'b0;
  logic [FW-1:0] freq_min = '0;
  logic [FW-1:0] freq_max = '0;
  logic [FW-1:0] freq_cur = '0;
  logic          freq_load;
  logic [FW-1:0] freq_set;
  logic          track_en;
  logic          locked;
  logic          holdover;
  logic [2:0]    state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic fb_run = 1'b0;

  pll_acq_ctrl #(
    .FW(FW), .DWELL_LOG2(5), .SWEEP_STEP(4), .WIN_LOG2(6),
    .LOCK_MAX(4), .LOCK_WINS(4), .NOSIG(50)
  ) dut (
    .clk_50(clk_50), .rst_n(rst_n), .enable(enable), .fb_edge(fb_edge),
    .slew_fast(slew_fast), .slew_slow(slew_slow),
    .freq_min(freq_min), .freq_max(freq_max), .freq_cur(freq_cur),
    .freq_load(freq_load), .freq_set(freq_set), .track_en(track_en),
    .locked(locked), .holdover(holdover), .state(state)
  );

  always #5 clk_50 = ~clk_50;

  // Advance one clock; outputs are sampled 1ns after the edge, feedback pulses every 8 cycles.
  task automatic step();
    @(posedge clk_50);
    #1;
    cyc++;
    fb_edge = fb_run && (cyc % 8 == 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; fb_run = 1'b0;
    step(); step();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
    total++; if (freq_set !== 10'd0) begin bad++; $display("FAIL reset_freq_set: got %0d want 0", freq_set); end
    total++; if (freq_load !== 1'b0) begin bad++; $display("FAIL reset_freq_load: got %b want 0", freq_load); end
    total++; if ({track_en, locked, holdover} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {track_en, locked, holdover}); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_sweep();
    int exp_v[7];
    int prev;
    int n;
    exp_v = '{20, 24, 28, 32, 36, 40, 20};
    freq_min = 10'd20; freq_max = 10'd40; freq_cur = 10'd30; enable = 1'b1;
    prev = 0;
    for (int i = 0; i < 7; i++) begin
      n = 0;
      while (freq_load !== 1'b1 && n < 40) begin step(); n++; end
      total++; if (freq_load !== 1'b1) begin bad++; $display("FAIL sweep_load_seen: step %0d got no load after %0d cycles, want a load", i, n); end
      total++; if (freq_set !== 10'(exp_v[i])) begin bad++; $display("FAIL sweep_value: step %0d got %0d want %0d", i, freq_set, exp_v[i]); end
      total++; if (state !== 3'd1) begin bad++; $display("FAIL sweep_state: step %0d got %0d want 1", i, state); end
      if (i > 0) begin
        total++; if (cyc - prev != 32) begin bad++; $display("FAIL sweep_spacing: step %0d got %0d want 32", i, cyc - prev); end
      end
      prev = cyc;
      step();
      total++; if (freq_load !== 1'b0) begin bad++; $display("FAIL sweep_load_width: step %0d got %b want 0", i, freq_load); end
    end
  endtask

  task automatic test_sweep_to_lock();
    int n;
    int t;
    n = 0;
    while (!(freq_load === 1'b1 && freq_set === 10'd28) && n < 200) begin step(); n++; end
    total++; if (!(freq_load === 1'b1 && freq_set === 10'd28)) begin bad++; $display("FAIL lock_reach28: got freq_set %0d load %b want 28 1", freq_set, freq_load); end
    fb_run = 1'b1;
    repeat (32) step();
    total++; if (state !== 3'd2) begin bad++; $display("FAIL lock_track_entry: got %0d want 2", state); end
    total++; if (freq_set !== 10'd28 || freq_load !== 1'b1) begin bad++; $display("FAIL lock_track_load: got %0d/%b want 28/1", freq_set, freq_load); end
    total++; if (track_en !== 1'b1 || locked !== 1'b0) begin bad++; $display("FAIL lock_track_flags: got %b%b want 10", track_en, locked); end
    t = cyc;
    n = 0;
    while (locked !== 1'b1 && n < 400) begin step(); n++; end
    total++; if (cyc - t != 256) begin bad++; $display("FAIL lock_latency: got %0d want 256", cyc - t); end
    total++; if (state !== 3'd3) begin bad++; $display("FAIL lock_state: got %0d want 3", state); end
  endtask

  task automatic test_loss_of_lock();
    int l;
    l = cyc;
    slew_fast = 1'b1;
    repeat (40) step();
    slew_fast = 1'b0;
    while (cyc < l + 63) step();
    total++; if (state !== 3'd3) begin bad++; $display("FAIL lol_before_end: got %0d want 3", state); end
    step();
    total++; if (state !== 3'd2 || locked !== 1'b0) begin bad++; $display("FAIL lol_track: got state %0d locked %b want 2 0", state, locked); end
    total++; if (track_en !== 1'b1) begin bad++; $display("FAIL lol_track_en: got %b want 1", track_en); end
  endtask

  task automatic test_rail();
    int t;
    t = cyc;
    freq_cur = 10'd40;
    while (cyc < t + 63) step();
    total++; if (state !== 3'd2) begin bad++; $display("FAIL rail_before_end: got %0d want 2", state); end
    step();
    total++; if (state !== 3'd1) begin bad++; $display("FAIL rail_state: got %0d want 1", state); end
    total++; if (freq_set !== 10'd20 || freq_load !== 1'b1) begin bad++; $display("FAIL rail_reload: got %0d/%b want 20/1", freq_set, freq_load); end
  endtask

  task automatic test_loss_of_signal();
    int n;
    freq_cur = 10'd33;
    n = 0;
    while (locked !== 1'b1 && n < 400) begin step(); n++; end
    total++; if (state !== 3'd3) begin bad++; $display("FAIL los_relock: got %0d want 3", state); end
    fb_run = 1'b0;
    repeat (45) step();
    total++; if (state !== 3'd3) begin bad++; $display("FAIL los_early: got %0d want 3", state); end
    n = 0;
    while (state === 3'd3 && n < 20) begin step(); n++; end
`ifdef PLL_ACQ_HOLDOVER_EN
    total++; if (state !== 3'd4 || holdover !== 1'b1) begin bad++; $display("FAIL los_holdover: got state %0d holdover %b want 4 1", state, holdover); end
    total++; if (freq_set !== 10'd33 || freq_load !== 1'b1) begin bad++; $display("FAIL los_capture: got %0d/%b want 33/1", freq_set, freq_load); end
    total++; if (track_en !== 1'b0 || locked !== 1'b0) begin bad++; $display("FAIL los_flags: got %b%b want 00", track_en, locked); end
    fb_run = 1'b1;
    n = 0;
    while (state === 3'd4 && n < 20) begin step(); n++; end
    total++; if (state !== 3'd2 || holdover !== 1'b0) begin bad++; $display("FAIL los_resume: got state %0d holdover %b want 2 0", state, holdover); end
`else
    total++; if (state !== 3'd1 || holdover !== 1'b0) begin bad++; $display("FAIL los_sweep: got state %0d holdover %b want 1 0", state, holdover); end
    total++; if (freq_set !== 10'd20 || freq_load !== 1'b1) begin bad++; $display("FAIL los_reload: got %0d/%b want 20/1", freq_set, freq_load); end
    total++; if (track_en !== 1'b0 || locked !== 1'b0) begin bad++; $display("FAIL los_flags: got %b%b want 00", track_en, locked); end
    fb_run = 1'b1;
`endif
  endtask

  task automatic test_enable_priority();
    int n;
    int t;
    enable = 1'b0;
    step();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL en_idle: got %0d want 0", state); end
    freq_cur = 10'd30; fb_run = 1'b1; enable = 1'b1;
    n = 0;
    while (state !== 3'd2 && n < 60) begin step(); n++; end
    total++; if (state !== 3'd2 || freq_set !== 10'd20) begin bad++; $display("FAIL en_track: got state %0d freq %0d want 2 20", state, freq_set); end
    t = cyc;
    while (cyc < t + 255) step();
    total++; if (state !== 3'd2 || locked !== 1'b0) begin bad++; $display("FAIL en_prelock: got state %0d locked %b want 2 0", state, locked); end
    enable = 1'b0;
    step();
    total++; if (state !== 3'd0 || locked !== 1'b0 || track_en !== 1'b0) begin bad++; $display("FAIL en_drop: got state %0d locked %b track %b want 0 0 0", state, locked, track_en); end
    total++; if (freq_set !== 10'd20 || freq_load !== 1'b0) begin bad++; $display("FAIL en_hold_freq: got %0d/%b want 20/0", freq_set, freq_load); end
  endtask

  task automatic test_reset_mid_dwell();
    int loads;
    fb_run = 1'b0; enable = 1'b1;
    step();
    total++; if (state !== 3'd1 || freq_load !== 1'b1) begin bad++; $display("FAIL rst_sweep_start: got state %0d load %b want 1 1", state, freq_load); end
    repeat (10) step();
    rst_n = 1'b0;
    step();
    total++; if (state !== 3'd0 || freq_set !== 10'd0) begin bad++; $display("FAIL rst_mid_state: got state %0d freq %0d want 0 0", state, freq_set); end
    total++; if ({freq_load, track_en, locked, holdover} !== 4'b0000) begin bad++; $display("FAIL rst_mid_flags: got %b want 0000", {freq_load, track_en, locked, holdover}); end
    loads = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (freq_load === 1'b1) loads++;
    end
    total++; if (loads != 0) begin bad++; $display("FAIL rst_no_load: got %0d loads want 0", loads); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_sweep_to_lock();
    test_loss_of_lock();
    test_rail();
    test_loss_of_signal();
    test_enable_priority();
    test_reset_mid_dwell();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
